// File: rtl/fpu_add_sched.sv
// fpu_add_sched: shares one combinational single-precision FP adder between
// two requesters. Arbitrates, registers operands (sign of b flipped for
// subtraction), holds them on the adder for LAT cycles, captures the sum and
// returns it with requester id and tag over a valid/ready response channel.
// Optional feature: define FPU_SCHED_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module fpu_add_sched #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic             req0_sub_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic             req1_sub_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic [31:0]      add_a_o,
  output logic [31:0]      add_b_o,
  input  logic [31:0]      add_z_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef FPU_SCHED_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      res;
  logic [TAG_W-1:0] tag_q;
  logic             id_q;
  logic             last_grant;

  logic             grant;
  logic             accept;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_sub;
  logic [TAG_W-1:0] sel_tag;

  // Arbitration: a lone valid requester always wins; on contention either
  // fixed priority to requester 0 or the one not granted last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i)
      grant = RR_EN ? ~last_grant : 1'b0;
    else if (req1_valid_i)
      grant = 1'b1;
  end

  // Handshake and operand selection for the granted requester.
  always_comb begin
    req0_ready_o = (state == IDLE) && !grant && req0_valid_i;
    req1_ready_o = (state == IDLE) &&  grant && req1_valid_i;
    accept       = req0_ready_o || req1_ready_o;
    sel_a        = grant ? req1_a_i   : req0_a_i;
    sel_b        = grant ? req1_b_i   : req0_b_i;
    sel_sub      = grant ? req1_sub_i : req0_sub_i;
    sel_tag      = grant ? req1_tag_i : req0_tag_i;
  end

  // Sequencer: accept -> hold operands LAT cycles -> present result until taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      tag_q      <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= sel_a;
            op_b       <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
            tag_q      <= sel_tag;
            id_q       <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            res   <= add_z_i;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (rsp_ready_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs driven straight from state and holding registers.
  always_comb begin
    add_a_o     = op_a;
    add_b_o     = op_b;
    rsp_valid_o = (state == DONE);
    rsp_data_o  = res;
    rsp_id_o    = id_q;
    rsp_tag_o   = tag_q;
    busy_o      = (state != IDLE);
  end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Testbench for fpu_add_sched: directed cases plus randomized traffic checked
// against a transaction-level reference model of the scheduler.
module tb_fpu_add_sched;
  localparam int unsigned LAT   = 4;
  localparam int unsigned TAG_W = 5;

`ifdef FPU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic             req0_ready_o, req1_ready_o;
  logic [31:0]      req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
  logic             req0_sub_i = 1'b0, req1_sub_i = 1'b0;
  logic [TAG_W-1:0] req0_tag_i = '0, req1_tag_i = '0;
  logic [31:0]      add_a_o, add_b_o, add_z_i;
  logic             rsp_valid_o, rsp_ready_i = 1'b1, rsp_id_o, busy_o;
  logic [31:0]      rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_add_sched #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_sub_i(req0_sub_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_sub_i(req1_sub_i), .req1_tag_i(req1_tag_i),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_z_i(add_z_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_id_o(rsp_id_o), .rsp_tag_o(rsp_tag_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Single <-> double conversion for normal numbers; subnormals flush to zero.
  function automatic real sp2real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) d = {x[31], 63'b0};
    else d = {x[31], ({3'b0, x[30:23]} + 11'd896), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0)   return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    real r;
    r = sub ? (sp2real(a) - sp2real(b)) : (sp2real(a) + sp2real(b));
    return real2sp(r);
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Adder attached to the scheduler.
  always_comb add_z_i = real2sp(sp2real(add_a_o) + sp2real(add_b_o));

  // Reference model state: one outstanding operation at a time.
  bit               mon_en = 1'b0;
  bit               m_busy = 1'b0;
  bit               m_last = 1'b1;
  int               m_t    = 0;
  logic [31:0]      m_a, m_b;
  logic             m_sub, m_id;
  logic [TAG_W-1:0] m_tag;
  bit               acc0_q = 1'b0, acc1_q = 1'b0;
  int               acc_cyc = 0;
  bit               id_log[$];
  bit               has, w, er0, er1, erv;

  always @(negedge clk) begin
    acc0_q = req0_valid_i && req0_ready_o;
    acc1_q = req1_valid_i && req1_ready_o;
    if (mon_en) begin
      has = req0_valid_i || req1_valid_i;
      if (req0_valid_i && req1_valid_i) w = RR ? !m_last : 1'b0;
      else w = !req0_valid_i;
      er0 = !m_busy && has && !w;
      er1 = !m_busy && has && w;
      erv = m_busy && (cyc >= m_t + int'(LAT) + 1);
      check("ready0", req0_ready_o, er0);
      check("ready1", req1_ready_o, er1);
      check("busy", busy_o, m_busy);
      check("rsp_valid", rsp_valid_o, erv);
      if (m_busy && cyc > m_t) begin
        check("add_a", add_a_o, m_a);
        check("add_b", add_b_o, m_sub ? {~m_b[31], m_b[30:0]} : m_b);
      end
      if (erv) begin
        check("rsp_data", rsp_data_o, ref_op(m_a, m_b, m_sub));
        check("rsp_id", rsp_id_o, m_id);
        check("rsp_tag", rsp_tag_o, m_tag);
      end
      if (!rst) begin
        m_busy = 1'b0;
        m_last = 1'b1;
      end else if (er0 || er1) begin
        m_a = er1 ? req1_a_i : req0_a_i;
        m_b = er1 ? req1_b_i : req0_b_i;
        m_sub = er1 ? req1_sub_i : req0_sub_i;
        m_tag = er1 ? req1_tag_i : req0_tag_i;
        m_id = er1;
        m_last = er1;
        m_t = cyc;
        acc_cyc = cyc;
        m_busy = 1'b1;
        id_log.push_back(er1);
      end else if (erv && rsp_ready_i) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    mon_en = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ready0"}, req0_ready_o, 0);
    check({pfx, "_ready1"}, req1_ready_o, 0);
    check({pfx, "_rsp_valid"}, rsp_valid_o, 0);
    check({pfx, "_busy"}, busy_o, 0);
    check({pfx, "_add_a"}, add_a_o, 0);
    check({pfx, "_add_b"}, add_b_o, 0);
    check({pfx, "_rsp_data"}, rsp_data_o, 0);
    check({pfx, "_rsp_tag"}, rsp_tag_o, 0);
    check({pfx, "_rsp_id"}, rsp_id_o, 0);
  endtask

  task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [TAG_W-1:0] tag);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (!n) begin
      req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_sub_i = sub; req0_tag_i = tag;
    end else begin
      req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_sub_i = sub; req1_tag_i = tag;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      got = n ? acc1_q : acc0_q;
    end
    check("issue_accepted", got, 1);
    @(posedge clk); #1;
    if (!n) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int i;
    i = 0;
    while (!rsp_valid_o && i < 100) begin
      @(negedge clk); #1;
      if (busy_o && !rsp_valid_o && add_a_o == 32'h40400000)
        check("sub_add_b_exec", add_b_o, 32'hBF800000);
      i++;
    end
    check("rsp_timeout", rsp_valid_o, 1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (busy_o && i < 100) begin
      @(negedge clk); #1;
      i++;
    end
    check("drain_idle", busy_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [31:0] ea;
    logic [31:0] eb;

    // Reset state.
    do_reset(3);
    @(negedge clk); #1;
    check_zero("reset");

    // Add: 1.0 + 2.0 = 3.0 from requester 0.
    issue(0, 32'h3F800000, 32'h40000000, 1'b0, 5'd5);
    wait_rsp();
    check("add_data", rsp_data_o, 32'h40400000);
    check("add_id", rsp_id_o, 0);
    check("add_tag", rsp_tag_o, 5);
    check("add_latency", cyc - acc_cyc, LAT + 1);

    // Sub: 3.0 - 1.0 = 2.0 from requester 1; b sign flipped throughout EXEC.
    issue(1, 32'h40400000, 32'h3F800000, 1'b1, 5'd11);
    wait_rsp();
    check("sub_data", rsp_data_o, 32'h40000000);
    check("sub_id", rsp_id_o, 1);
    check("sub_tag", rsp_tag_o, 11);
    drain();

    // Sign flip applies to NaN too.
    issue(0, 32'h3F800000, 32'h7FC00000, 1'b1, 5'd3);
    check("nan_flip", add_b_o, 32'hFFC00000);
    wait_rsp();
    drain();

    // Contention from reset: both requesters valid continuously.
    do_reset(2);
    start = id_log.size();
    @(posedge clk); #1;
    req0_valid_i = 1'b1; req0_a_i = rnd_fp(); req0_b_i = rnd_fp(); req0_sub_i = 1'b0; req0_tag_i = 5'd1;
    req1_valid_i = 1'b1; req1_a_i = rnd_fp(); req1_b_i = rnd_fp(); req1_sub_i = 1'b1; req1_tag_i = 5'd2;
    for (int i = 0; i < 300 && id_log.size() < start + 6; i++) begin
      @(posedge clk); #1;
      if (acc0_q) begin req0_a_i = rnd_fp(); req0_b_i = rnd_fp(); end
      if (acc1_q) begin req1_a_i = rnd_fp(); req1_b_i = rnd_fp(); end
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    check("cont_count", id_log.size() >= start + 6, 1);
    for (int k = 0; k < 6 && start + k < id_log.size(); k++)
      check("cont_id", id_log[start + k], RR ? (k % 2) : 0);
    drain();

    // Backpressure: result held 5 cycles while requester 1 waits.
    rsp_ready_i = 1'b0;
    ea = rnd_fp(); eb = rnd_fp();
    issue(0, ea, eb, 1'b0, 5'd7);
    req1_valid_i = 1'b1; req1_a_i = 32'h3F800000; req1_b_i = 32'h3F800000;
    req1_sub_i = 1'b0; req1_tag_i = 5'd9;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid_o, 1);
      check("bp_data", rsp_data_o, ref_op(ea, eb, 1'b0));
      check("bp_tag", rsp_tag_o, 7);
      check("bp_ready0", req0_ready_o, 0);
      check("bp_ready1", req1_ready_o, 0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("bp_idle_busy", busy_o, 0);
    check("bp_idle_ready1", req1_ready_o, 1);
    @(posedge clk); #1 req1_valid_i = 1'b0;
    wait_rsp();
    check("bp_next_data", rsp_data_o, 32'h40000000);
    drain();

    // Reset in the 2nd EXEC cycle discards the operation.
    issue(0, 32'h40400000, 32'h40400000, 1'b0, 5'd4);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    check_zero("midrst");
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(negedge clk); #1;
      check("midrst_no_rsp", rsp_valid_o, 0);
    end
    issue(1, 32'h40000000, 32'h40000000, 1'b0, 5'd6);
    wait_rsp();
    check("midrst_next_data", rsp_data_o, 32'h40800000);
    check("midrst_next_id", rsp_id_o, 1);
    check("midrst_next_tag", rsp_tag_o, 6);
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!req0_valid_i || acc0_q) begin
        req0_valid_i = ($urandom_range(0, 2) != 0);
        req0_a_i = rnd_fp(); req0_b_i = rnd_fp();
        req0_sub_i = 1'($urandom_range(0, 1)); req0_tag_i = TAG_W'($urandom);
      end
      if (!req1_valid_i || acc1_q) begin
        req1_valid_i = ($urandom_range(0, 2) != 0);
        req1_a_i = rnd_fp(); req1_b_i = rnd_fp();
        req1_sub_i = 1'($urandom_range(0, 1)); req1_tag_i = TAG_W'($urandom);
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_add_sched.md
Name: fpu_add_sched

Overview:
- Sequencer and arbiter that shares the single combinational single-precision FP adder between two requesters, e.g. the EX stage and a future FP coprocessor port.
- Arbitrates requests and registers operands.
- Applies subtraction by flipping the sign bit of b.
- Holds the operands stable on the adder for a programmable settle time, captures the sum and returns it with requester ID and tag over a valid/ready response channel.

Parameters:
- LAT, 1, cycles the operands are held on the adder before the result is captured; legal range 1..15.
- TAG_W, 5, width of the opaque requester tag returned with the result, e.g. a destination register index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active low
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_a_i  in  32  operand a, IEEE754 single precision
- req0_b_i  in  32  operand b, IEEE754 single precision
- req0_sub_i  in  1  1 = a-b, 0 = a+b
- req0_tag_i  in  TAG_W  tag for requester 0
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_sub_i, req1_tag_i  same as requester 0, for requester 1
- add_a_o  out  32  operand a to the adder
- add_b_o  out  32  operand b to the adder, sign already adjusted
- add_z_i  in  32  adder result
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer takes result
- rsp_data_o  out  32  captured sum
- rsp_id_o  out  1  requester that issued the operation
- rsp_tag_o  out  TAG_W  tag of that operation
- busy_o  out  1  state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock; every register updates on the rising edge of clk.
  - rst low at an edge forces: state=IDLE, the operand, result, tag and id registers to 0, cnt=0, last_grant=1.
  - All outputs read 0 after reset: ready, rsp_valid, busy, add_a_o, add_b_o, rsp_data_o, rsp_tag_o, rsp_id_o.
- State machine, 3 states:
  - IDLE:
    - reqN_ready_o = (state==IDLE) & grant==N & reqN_valid_i. This is combinational; at most one ready is high.
    - Accept occurs when valid&ready. On accept, register: a, b with bit31 XOR sub, tag, id=N, cnt=LAT-1, last_grant=N. Next state is EXEC.
    - With no valid request, the block stays in IDLE.
  - EXEC:
    - add_a_o/add_b_o are driven from the operand registers in every state, so they are stable throughout EXEC.
    - If cnt==0: rsp_data_o <= add_z_i and the next state is DONE. Otherwise cnt decrements.
  - DONE:
    - rsp_valid_o=1.
    - rsp_data_o, rsp_id_o and rsp_tag_o are held until rsp_ready_i is high, then the next state is IDLE.
    - No accept happens in the DONE cycle; there is no bypass.
- Timing:
  - Latency: accept at edge T gives rsp_valid_o high from T+LAT+1.
  - Minimum issue interval is LAT+2 cycles.
- Arbitration when both requesters are valid:
  - Fixed priority: requester 0 wins.
  - See Optional Feature for round robin.
- Requester rules:
  - A requester must hold valid and its data stable until accepted.
  - The scheduler never drops or reorders an accepted operation.
- Backpressure: rsp_ready_i low holds DONE indefinitely. Both ready outputs stay 0 during that time.
- Reset mid-operation: reset in EXEC or DONE discards the operation. No response is issued.
- No numeric special-casing in this block. NaN, Inf and zero handling belong to the adder; the sign flip is applied even when b is NaN.

Optional Feature:
- Macro: FPU_SCHED_RR_EN.
- Defined: round-robin arbitration. When both are valid, grant goes to the requester != last_grant. When only one is valid, it wins regardless.
- Undefined: fixed priority, requester 0 always wins. last_grant is still tracked but does not affect the grant.

Test Plan:
- Add, LAT=1:
  - Stimulus: req0 a=0x3F800000, b=0x40000000, sub=0, tag=5, adder model connected.
  - Required response: accept at T; rsp_valid at T+2 with data=0x40400000, id=0, tag=5; busy high T+1..T+2.
- Sub, LAT=3:
  - Stimulus: req1 a=0x40400000, b=0x3F800000, sub=1.
  - Required response: add_b_o=0xBF800000 for the whole EXEC phase; rsp at T+4 with data=0x40000000, id=1.
- Contention, macro undefined:
  - Stimulus: both valid continuously, tags 1 and 2.
  - Required response: responses in order id 0, 0, 0…; req1_ready_o never high while req0_valid_i is high.
- Contention, FPU_SCHED_RR_EN defined:
  - Stimulus: same as above.
  - Required response: ids alternate 0, 1, 0, 1; first grant goes to 0.
- Backpressure:
  - Stimulus: hold rsp_ready_i low 5 cycles in DONE.
  - Required response: rsp_valid, data and tag stable; both ready_o stay 0; IDLE the cycle after rsp_ready_i rises.
- Reset mid-EXEC, LAT=4:
  - Stimulus: assert rst low in the 2nd EXEC cycle.
  - Required response: next cycle all outputs 0; no response is issued; the next accepted request completes normally.
